// File: rtl/pps_meter_pkg.sv
// Shared types and default constants for the PPS period meter.
package pps_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOST    = 2'd2
    } state_e;

    localparam int unsigned DEF_CNT_W          = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 40_000_000;
    localparam int unsigned DEF_TOL            = 4;

endpackage

// File: rtl/pps_sync_edge.sv
// Multi-flop synchroniser followed by a registered rising-edge detector.
module pps_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;

    // Synchroniser chain, previous-value flop and one-cycle rise pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/pps_freq_meter.sv
// Counts clk cycles between PPS rising edges; reports period, overrun, loss and lock.
module pps_freq_meter
    import pps_meter_pkg::*;
#(
    parameter int unsigned CNT_W          = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned TOL            = DEF_TOL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pps_in,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             overrun,
    output logic             pps_lost,
    output logic             locked
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] meas_count_q, meas_count_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic             meas_valid_q, meas_valid_d;
    logic             overrun_q, overrun_d;
    logic             pps_lost_q, pps_lost_d;
    logic             locked_q, locked_d;
    logic             have_prev_q, have_prev_d;

    logic             pps_rise;
    logic             capture_c;
    logic             handshake_c;
    logic [CNT_W-1:0] diff_c;

    pps_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (pps_in),
        .rise (pps_rise)
    );

    // Unsigned distance between the new period and the previous one.
    assign diff_c = (cnt_q > prev_q) ? (cnt_q - prev_q) : (prev_q - cnt_q);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            meas_count_q <= '0;
            prev_q       <= '0;
            meas_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            pps_lost_q   <= 1'b0;
            locked_q     <= 1'b0;
            have_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            meas_count_q <= meas_count_d;
            prev_q       <= prev_d;
            meas_valid_q <= meas_valid_d;
            overrun_q    <= overrun_d;
            pps_lost_q   <= pps_lost_d;
            locked_q     <= locked_d;
            have_prev_q  <= have_prev_d;
        end
    end

    // Next-state, period counting, capture handshake and lock evaluation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        meas_count_d = meas_count_q;
        prev_d       = prev_q;
        meas_valid_d = meas_valid_q;
        overrun_d    = overrun_q;
        pps_lost_d   = pps_lost_q;
        locked_d     = locked_q;
        have_prev_d  = have_prev_q;
        capture_c    = 1'b0;
        handshake_c  = meas_valid_q & meas_ready;

        case (state_q)
            IDLE: begin
                if (pps_rise) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_W'(1);
                end
            end
            MEASURE: begin
                if (pps_rise) begin
                    capture_c = 1'b1;
                    cnt_d     = CNT_W'(1);
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d     = LOST;
                    pps_lost_d  = 1'b1;
                    locked_d    = 1'b0;
                    have_prev_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOST: begin
                if (pps_rise) begin
                    state_d    = MEASURE;
                    cnt_d      = CNT_W'(1);
                    pps_lost_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A capture in a handshake cycle replaces the consumed sample cleanly.
        if (capture_c) begin
            meas_count_d = cnt_q;
            meas_valid_d = 1'b1;
            overrun_d    = meas_valid_q & ~meas_ready;
            prev_d       = cnt_q;
            have_prev_d  = 1'b1;
            if (have_prev_q) begin
                locked_d = (diff_c <= CNT_W'(TOL));
            end
        end else if (handshake_c) begin
            meas_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end
    end

    assign meas_count = meas_count_q;
    assign meas_valid = meas_valid_q;
    assign overrun    = overrun_q;
    assign pps_lost   = pps_lost_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_pps_freq_meter.sv
// Self-checking bench for pps_freq_meter: timestamp-based model plus directed checks.
module tb_pps_freq_meter;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 1000;
    localparam int unsigned TOL     = 2;
    localparam int unsigned LAT     = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             pps_in = 1'b0;
    logic             meas_ready = 1'b0;
    logic [CNT_W-1:0] meas_count;
    logic             meas_valid;
    logic             overrun;
    logic             pps_lost;
    logic             locked;

    int checks = 0;
    int errors = 0;

    pps_freq_meter #(
        .CNT_W          (CNT_W),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TIMEOUT),
        .TOL            (TOL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pps_in     (pps_in),
        .meas_count (meas_count),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .overrun    (overrun),
        .pps_lost   (pps_lost),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: edges are timestamps; a period is the gap between two edge times.
    int unsigned cyc = 0;
    int unsigned det_q[$];
    bit          m_prev_p = 1'b0;
    bit          m_running = 1'b0;
    bit          m_have_prev = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_ovr = 1'b0;
    bit          m_lost = 1'b0;
    bit          m_locked = 1'b0;
    int unsigned m_t0 = 0;
    int unsigned m_prev = 0;
    int unsigned m_count = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            det_q.delete();
            m_prev_p    = 1'b0;
            m_running   = 1'b0;
            m_have_prev = 1'b0;
            m_valid     = 1'b0;
            m_ovr       = 1'b0;
            m_lost      = 1'b0;
            m_locked    = 1'b0;
            m_count     = 0;
            m_prev      = 0;
        end else begin
            bit          e;
            bit          cap;
            bit          hs;
            int unsigned per;
            int          dlt;
            cyc++;
            hs  = m_valid && meas_ready;
            e   = (det_q.size() > 0) && (det_q[0] == cyc);
            cap = 1'b0;
            per = 0;
            if (e) void'(det_q.pop_front());
            if (pps_in && !m_prev_p) det_q.push_back(cyc + LAT);
            m_prev_p = pps_in;

            if (e) begin
                if (m_running) begin
                    cap = 1'b1;
                    per = cyc - m_t0;
                end
                m_running = 1'b1;
                m_t0      = cyc;
                m_lost    = 1'b0;
            end else if (m_running && (cyc - m_t0 == TIMEOUT)) begin
                m_running   = 1'b0;
                m_lost      = 1'b1;
                m_have_prev = 1'b0;
                m_locked    = 1'b0;
            end

            if (cap) begin
                m_ovr   = m_valid && !hs;
                m_valid = 1'b1;
                m_count = per;
                if (m_have_prev) begin
                    dlt      = int'(per) - int'(m_prev);
                    if (dlt < 0) dlt = -dlt;
                    m_locked = (dlt <= int'(TOL));
                end
                m_prev      = per;
                m_have_prev = 1'b1;
            end else if (hs) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("mdl_valid", 32'(meas_valid), 32'(m_valid));
        check("mdl_count", 32'(meas_count), m_count);
        check("mdl_overrun", 32'(overrun), 32'(m_ovr));
        check("mdl_lost", 32'(pps_lost), 32'(m_lost));
        check("mdl_locked", 32'(locked), 32'(m_locked));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // One PPS period of n cycles starting with a rise; optional check at its capture.
    task automatic pulse(input int n, input bit chk, input int unsigned ecount,
                         input bit evalid, input bit elocked, input bit eovr, input bit hs);
        pps_in = 1'b1;
        for (int i = 1; i <= n; i++) begin
            step();
            if (i == 5) pps_in = 1'b0;
            if (hs && i == 3) meas_ready = 1'b1;
            if (hs && i == 4) meas_ready = 1'b0;
            if (chk && i == 4) begin
                @(negedge clk);
                check("dir_valid", 32'(meas_valid), 32'(evalid));
                check("dir_count", 32'(meas_count), ecount);
                check("dir_locked", 32'(locked), 32'(elocked));
                check("dir_overrun", 32'(overrun), 32'(eovr));
            end
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_valid", 32'(meas_valid), 0);
        check("rst_count", 32'(meas_count), 0);
        check("rst_lost", 32'(pps_lost), 0);
        step();
        step();
        rst = 1'b0;
        step();

        // Steady 500-cycle spacing, consumer always ready.
        meas_ready = 1'b1;
        pulse(500, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse(500, 1'b1, 500, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse(500, 1'b1, 500, 1'b1, 1'b1, 1'b0, 1'b0);
        pulse(500, 1'b1, 500, 1'b1, 1'b1, 1'b0, 1'b0);

        // Lock tolerance boundary: 500, 503, 501.
        do_reset();
        pulse(500, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse(503, 1'b1, 500, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse(501, 1'b1, 503, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse(500, 1'b1, 501, 1'b1, 1'b1, 1'b0, 1'b0);

        // Overrun when the consumer stalls across two captures.
        do_reset();
        meas_ready = 1'b0;
        pulse(500, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse(500, 1'b1, 500, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse(20, 1'b1, 500, 1'b1, 1'b1, 1'b1, 1'b0);
        meas_ready = 1'b1;
        step();
        meas_ready = 1'b0;
        @(negedge clk);
        check("hs_valid", 32'(meas_valid), 0);
        check("hs_overrun", 32'(overrun), 0);
        step();

        // Capture in the same cycle as a handshake.
        do_reset();
        pulse(500, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse(480, 1'b1, 500, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse(40, 1'b1, 480, 1'b1, 1'b0, 1'b0, 1'b1);
        check("coinc_valid_hold", 32'(meas_valid), 1);

        // PPS loss after a locked run, then recovery.
        do_reset();
        meas_ready = 1'b1;
        pulse(500, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse(500, 1'b1, 500, 1'b1, 1'b0, 1'b0, 1'b0);
        pps_in = 1'b1;
        for (int i = 1; i <= 1100; i++) begin
            step();
            if (i == 5) pps_in = 1'b0;
            if (i == 4) begin
                @(negedge clk);
                check("pre_loss_locked", 32'(locked), 1);
                check("pre_loss_count", 32'(meas_count), 500);
            end
            if (i == 1003) begin
                @(negedge clk);
                check("lost_early", 32'(pps_lost), 0);
            end
            if (i == 1004) begin
                @(negedge clk);
                check("lost_rise", 32'(pps_lost), 1);
                check("lost_locked", 32'(locked), 0);
            end
        end
        pulse(500, 1'b1, 500, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lost_cleared", 32'(pps_lost), 0);
        pulse(100, 1'b1, 500, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a period with a pending sample.
        do_reset();
        meas_ready = 1'b0;
        pulse(500, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse(250, 1'b1, 500, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(meas_valid), 0);
        check("mid_rst_count", 32'(meas_count), 0);
        check("mid_rst_overrun", 32'(overrun), 0);
        check("mid_rst_lost", 32'(pps_lost), 0);
        check("mid_rst_locked", 32'(locked), 0);
        #1;
        step();
        step();
        rst = 1'b0;
        step();
        pulse(500, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse(100, 1'b1, 500, 1'b1, 1'b0, 1'b0, 1'b0);

        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/pps_freq_meter.md
# pps_freq_meter

Downstream consumer of the one-second PPS pulse. Synchronises `pps_in` into its own clock domain and counts `clk` cycles between successive PPS rising edges. Each period count is offered on a valid/ready output. Also flags PPS loss, lost samples and period stability (lock), and is used to characterise or discipline the board oscillator against the PLL-derived one-second reference.

## Interface
- `CNT_W`, default 32: width of period counter and result.
- `SYNC_STAGES`, default 2: synchroniser flops on `pps_in`, minimum 2.
- `TIMEOUT_CYCLES`, default 40_000_000: cycles without an edge before declaring loss. Must be < 2^CNT_W − 1.
- `TOL`, default 4: maximum |Δ| between consecutive counts for lock.

Ports:
- `clk` in 1: single clock. All logic runs on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pps_in` in 1: asynchronous PPS pulse. Pulse width ≥ `SYNC_STAGES`+1 `clk` cycles.
- `meas_count` out `CNT_W`: last captured period in `clk` cycles.
- `meas_valid` out 1: `meas_count` valid.
- `meas_ready` in 1: consumer accepts on `meas_valid && meas_ready`.
- `overrun` out 1: offered sample replaced an unaccepted one.
- `pps_lost` out 1: no edge within `TIMEOUT_CYCLES`.
- `locked` out 1: last two periods within `TOL`.

## Operation
- **Edge detection:** `pps_in` passes through `SYNC_STAGES` flops. A registered previous value gives `edge` = sync_out & ~prev, one cycle wide.
- **FSM states:**
  - `IDLE` (reset state): waiting for the first edge.
    - `edge` → `MEASURE`, `cnt` := 1.
  - `MEASURE`: `cnt` := `cnt`+1 each cycle.
    - `edge` → capture `cnt` into `meas_count`, `cnt` := 1, stay in `MEASURE`.
    - `cnt` == `TIMEOUT_CYCLES` with no edge → `LOST`, `pps_lost` := 1, `locked` := 0, no capture.
  - `LOST`: `cnt` held.
    - `edge` → `MEASURE`, `cnt` := 1, `pps_lost` := 0. Like `IDLE`, this edge starts a period and produces no capture.
- **Period definition:** for edges detected at cycles t0 and t1, the captured value is t1−t0. For example, 1000 for a 1000-cycle spacing.
- **Capture handshake rules:**
  - Capture with `meas_valid`=0: load, `meas_valid` := 1, `overrun` := 0.
  - Capture with `meas_valid`=1 and no handshake that cycle: overwrite, `overrun` := 1.
  - Capture in the same cycle as a handshake: old value is consumed, new value loaded, `meas_valid` stays 1, `overrun` := 0.
  - Handshake without capture: `meas_valid` := 0, `overrun` := 0.
  - `meas_count` is stable while `meas_valid`=1, except on overwrite.
- **Lock:**
  - Keep the previous captured count plus a `have_prev` flag.
  - On capture with `have_prev`: `locked` := (|new − prev| ≤ `TOL`), computed unsigned as max − min.
  - First capture after reset or after `LOST`: `have_prev` := 1, `locked` unchanged (0).
  - Entering `LOST` clears `have_prev` and `locked`.
- **Reset values (all asynchronous):**
  - FSM `IDLE`, `cnt` 0, synchroniser and prev flops 0.
  - `meas_count` 0, `meas_valid` 0, `overrun` 0, `pps_lost` 0, `locked` 0, `have_prev` 0.
- **Reset mid-operation:** discards any pending sample. No spurious edge is detected on the release cycle, because the flops reset to 0.

## Timing
- `pps_in` first sampled high at clock edge k → `edge` asserted during cycle k+`SYNC_STAGES`.
- `meas_valid`, `meas_count`, `overrun` and `locked` update at edge k+`SYNC_STAGES`+1.
- `pps_lost` rises on the clock edge where `cnt` == `TIMEOUT_CYCLES` is evaluated, i.e. `TIMEOUT_CYCLES` cycles after the last edge.
- The handshake is sampled on the rising edge. `meas_valid` deasserts on the next edge.
- There is no combinational path from `meas_ready` to any output.

## Structure
- Package `pps_meter_pkg` holds:
  - the state encoding `IDLE`/`MEASURE`/`LOST`;
  - default constants for `CNT_W`, `TIMEOUT_CYCLES` and `TOL`.
- Sub-module `pps_sync_edge` (parameter `SYNC_STAGES`; ports `clk`, `rst`, `d`, `rise`) contains the synchroniser and edge detector. It is reused for other asynchronous strobes.

## Test plan
Bench parameters throughout: `CNT_W`=16, `TIMEOUT_CYCLES`=1000, `TOL`=2, `SYNC_STAGES`=2.

1. Edges every 500 cycles, `meas_ready`=1 → first edge gives no output. Each subsequent edge gives `meas_count`=500 for one cycle, `meas_valid` 3 cycles after `pps_in` rises. `locked`=1 from the 2nd capture.
2. Periods 500, 503, 501 → `locked` sequence 0, 0, 1. 503 vs 500 is Δ=3 > `TOL`; 501 vs 503 is Δ=2.
3. `meas_ready`=0 across two captures (500, 500) → `meas_valid` stays 1, `overrun`=1 after the 2nd. A handshake clears both.
4. Capture coincides with a handshake → new value present next cycle, `meas_valid`=1, `overrun`=0.
5. Stop `pps_in` after one period → `pps_lost`=1 exactly 1000 cycles after the last detected edge, `locked`=0. The next edge clears `pps_lost` without output. The edge after that yields a count.
6. Assert `rst` 250 cycles into a period while `meas_valid`=1 → all outputs 0 immediately. The first edge after release produces no capture.
